// File: rtl/wb_regfile_pipe_if.sv
// W-stage commit bus, D-stage read ports and debug/status taps of the
// Y86-64 register file.
interface wb_regfile_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
);
  logic              w_valid;
  logic [2:0]        w_stat;
  logic [ADDR_W-1:0] w_dstE;
  logic [ADDR_W-1:0] w_dstM;
  logic [DATA_W-1:0] w_valE;
  logic [DATA_W-1:0] w_valM;
  logic [ADDR_W-1:0] d_srcA;
  logic [ADDR_W-1:0] d_srcB;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] sp_val;
  logic [2:0]        stat_out;
  logic              halted;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output w_valid, w_stat, w_dstE, w_dstM, w_valE, w_valM,
           d_srcA, d_srcB, dbg_addr,
    input  d_valA, d_valB, dbg_data, sp_val, stat_out, halted, retire_cnt
  );

  modport slave (
    input  w_valid, w_stat, w_dstE, w_dstM, w_valE, w_valM,
           d_srcA, d_srcB, dbg_addr,
    output d_valA, d_valB, dbg_data, sp_val, stat_out, halted, retire_cnt
  );
endinterface

// File: rtl/wb_regfile_pipe.sv
// Y86-64 register file + write-back: commits W-stage results, serves two
// bypassed D-stage read ports, latches first fault status and counts retires.
module wb_rf_rdport #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREG   = 15
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_dstE,
  input  logic [ADDR_W-1:0] i_dstM,
  input  logic [DATA_W-1:0] i_valE,
  input  logic [DATA_W-1:0] i_valM,
  input  logic [DATA_W-1:0] i_arr,
  output logic [DATA_W-1:0] o_val
);
  // valM wins over valE, matching the commit priority for popq %rsp
  always_comb begin
    o_val = i_arr;
    if (i_src >= ADDR_W'(NREG))            o_val = '0;
    else if (i_we && (i_src == i_dstM))    o_val = i_valM;
    else if (i_we && (i_src == i_dstE))    o_val = i_valE;
  end
endmodule

module wb_regfile_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREG   = 15,
  parameter int SP_ID  = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_regfile_pipe_if.slave bus
);
  localparam logic [2:0] AOK       = 3'd1;
  localparam int         NUM_LANES = 2;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [2:0]        r_stat;
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic                               w_we;
  logic                               w_dstE_ok;
  logic                               w_dstM_ok;
  logic [NUM_LANES-1:0][ADDR_W-1:0]   w_src;
  logic [NUM_LANES-1:0][DATA_W-1:0]   w_arr;
  logic [NUM_LANES-1:0][DATA_W-1:0]   w_rd;

  assign w_we      = bus.w_valid && (bus.w_stat == AOK) && !r_halted;
  assign w_dstE_ok = bus.w_dstE < ADDR_W'(NREG);
  assign w_dstM_ok = bus.w_dstM < ADDR_W'(NREG);

  function automatic logic [DATA_W-1:0] f_rd(input logic [ADDR_W-1:0] a);
    f_rd = '0;
    if (a < ADDR_W'(NREG)) f_rd = r_regs[a];
  endfunction

  // M write issued last so it overrides E when both target the same ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      if (w_dstE_ok) r_regs[bus.w_dstE] <= bus.w_valE;
      if (w_dstM_ok) r_regs[bus.w_dstM] <= bus.w_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat   <= AOK;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.w_valid && !r_halted) begin
      if (bus.w_stat != AOK) begin
        r_stat   <= bus.w_stat;
        r_halted <= 1'b1;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_src = {bus.d_srcB, bus.d_srcA};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_rd
    assign w_arr[l] = f_rd(w_src[l]);
    wb_rf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_rd (
      .i_src  (w_src[l]),
      .i_we   (w_we),
      .i_dstE (bus.w_dstE),
      .i_dstM (bus.w_dstM),
      .i_valE (bus.w_valE),
      .i_valM (bus.w_valM),
      .i_arr  (w_arr[l]),
      .o_val  (w_rd[l])
    );
  end

  assign bus.d_valA     = w_rd[0];
  assign bus.d_valB     = w_rd[1];
  assign bus.dbg_data   = f_rd(bus.dbg_addr);
  assign bus.sp_val     = r_regs[SP_ID];
  assign bus.stat_out   = r_stat;
  assign bus.halted     = r_halted;
  assign bus.retire_cnt = r_cnt;
endmodule

// File: tb/tb_wb_regfile_pipe.sv
// Directed bench for wb_regfile_pipe: default instance plus a CNT_W=3
// instance for counter saturation.
module tb_wb_regfile_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_regfile_pipe_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(32)) rf ();
  wb_regfile_pipe_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(3))  rs ();

  wb_regfile_pipe #(.DATA_W(64), .ADDR_W(4), .NREG(15), .SP_ID(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(rf));
  wb_regfile_pipe #(.DATA_W(64), .ADDR_W(4), .NREG(15), .SP_ID(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(rs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.w_valid = 1'b0; rf.w_stat = 3'd1;
    rf.w_dstE = 4'hF;  rf.w_dstM = 4'hF;
    rf.w_valE = '0;    rf.w_valM = '0;
    rf.d_srcA = 4'hF;  rf.d_srcB = 4'hF; rf.dbg_addr = 4'hF;
  endtask

  task automatic wr(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    rf.w_valid = 1'b1; rf.w_stat = st;
    rf.w_dstE = de; rf.w_valE = ve;
    rf.w_dstM = dm; rf.w_valM = vm;
  endtask

  initial begin
    idle();
    rs.w_valid = 1'b0; rs.w_stat = 3'd1; rs.w_dstE = 4'hF; rs.w_dstM = 4'hF;
    rs.w_valE = '0; rs.w_valM = '0; rs.d_srcA = 4'hF; rs.d_srcB = 4'hF; rs.dbg_addr = 4'hF;

    // reset state
    #12;
    chk("rst_stat", rf.stat_out, 64'd1);
    chk("rst_halted", rf.halted, 64'd0);
    chk("rst_cnt", rf.retire_cnt, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rf.d_srcA = 4'(i); rf.d_srcB = 4'(i); #1;
      chk($sformatf("rst_rdA%0d", i), rf.d_valA, 64'd0);
      chk($sformatf("rst_rdB%0d", i), rf.d_valB, 64'd0);
    end

    // write reg3 with same-cycle bypass
    step();
    wr(3'd1, 4'd3, 64'h1234, 4'hF, 64'h0);
    rf.d_srcA = 4'd3; #1;
    chk("byp_e3", rf.d_valA, 64'h1234);
    chk("dbg_pre", rf.dbg_data, 64'h0);
    step();
    idle(); rf.d_srcA = 4'd3; rf.dbg_addr = 4'd3; #1;
    chk("arr_r3", rf.d_valA, 64'h1234);
    chk("dbg_r3", rf.dbg_data, 64'h1234);
    chk("cnt1", rf.retire_cnt, 64'd1);

    // popq %rsp: valM wins
    step();
    wr(3'd1, 4'd4, 64'h100, 4'd4, 64'hBEEF);
    rf.d_srcA = 4'd4; rf.d_srcB = 4'd4; #1;
    chk("popq_bypA", rf.d_valA, 64'hBEEF);
    chk("popq_bypB", rf.d_valB, 64'hBEEF);
    chk("popq_sp_pre", rf.sp_val, 64'h0);
    step();
    idle(); rf.d_srcA = 4'd4; #1;
    chk("popq_sp", rf.sp_val, 64'hBEEF);
    chk("popq_arr", rf.d_valA, 64'hBEEF);
    chk("cnt2", rf.retire_cnt, 64'd2);

    // dual write to distinct registers
    step();
    wr(3'd1, 4'd4, 64'h4444, 4'd7, 64'h7777);
    rf.d_srcA = 4'd4; rf.d_srcB = 4'd7; #1;
    chk("dual_bypE", rf.d_valA, 64'h4444);
    chk("dual_bypM", rf.d_valB, 64'h7777);
    step();
    idle(); rf.dbg_addr = 4'd7; #1;
    chk("dual_sp", rf.sp_val, 64'h4444);
    chk("dual_r7", rf.dbg_data, 64'h7777);
    chk("cnt3", rf.retire_cnt, 64'd3);

    // cmov not taken / invalid IDs: no write, still retires
    step();
    wr(3'd1, 4'hF, 64'hDEAD, 4'hF, 64'hCAFE);
    rf.d_srcA = 4'd15; rf.d_srcB = 4'hF; #1;
    chk("rnone_A", rf.d_valA, 64'h0);
    chk("rnone_B", rf.d_valB, 64'h0);
    step();
    idle(); rf.d_srcA = 4'd3; rf.dbg_addr = 4'd4; #1;
    chk("cmov_cnt", rf.retire_cnt, 64'd4);
    chk("cmov_r3", rf.d_valA, 64'h1234);
    chk("cmov_r4", rf.dbg_data, 64'h4444);

    // bubble with garbage fields changes nothing
    step();
    rf.w_valid = 1'b0; rf.w_stat = 3'd2; rf.w_dstE = 4'd1; rf.w_valE = 64'h99;
    rf.d_srcA = 4'd1; #1;
    chk("bub_nobyp", rf.d_valA, 64'h0);
    step();
    idle(); rf.dbg_addr = 4'd1; #1;
    chk("bub_r1", rf.dbg_data, 64'h0);
    chk("bub_halt", rf.halted, 64'd0);
    chk("bub_cnt", rf.retire_cnt, 64'd4);

    // HLT: no write, latch status
    step();
    wr(3'd2, 4'd1, 64'h55, 4'hF, 64'h0);
    rf.d_srcA = 4'd1; #1;
    chk("hlt_nobyp", rf.d_valA, 64'h0);
    step();
    idle(); rf.dbg_addr = 4'd1; #1;
    chk("hlt_r1", rf.dbg_data, 64'h0);
    chk("hlt_halt", rf.halted, 64'd1);
    chk("hlt_stat", rf.stat_out, 64'd2);
    chk("hlt_cnt", rf.retire_cnt, 64'd4);

    // AOK after halt is ignored
    step();
    wr(3'd1, 4'd1, 64'h66, 4'hF, 64'h0);
    rf.d_srcA = 4'd1; #1;
    chk("frz_nobyp", rf.d_valA, 64'h0);
    step();
    idle(); rf.dbg_addr = 4'd1; rf.d_srcB = 4'd3; #1;
    chk("frz_r1", rf.dbg_data, 64'h0);
    chk("frz_cnt", rf.retire_cnt, 64'd4);
    chk("frz_stat", rf.stat_out, 64'd2);
    chk("frz_read", rf.d_valB, 64'h1234);

    // saturation on CNT_W=3 instance, bubbles interleaved
    for (int i = 0; i < 9; i++) begin
      rs.w_valid = 1'b1; step();
      rs.w_valid = 1'b0; rs.w_stat = 3'd4; step();
      rs.w_stat = 3'd1;
      if (i == 2) chk("sat_cnt3", rs.retire_cnt, 64'd3);
    end
    chk("sat_cnt7", rs.retire_cnt, 64'd7);
    chk("sat_nohalt", rs.halted, 64'd0);
    rs.w_valid = 1'b1; rs.w_stat = 3'd0; step();
    rs.w_valid = 1'b0; rs.w_stat = 3'd1;
    chk("unk_stat", rs.stat_out, 64'd0);
    chk("unk_halt", rs.halted, 64'd1);

    // asynchronous reset mid-write, checked before the next edge
    rf.dbg_addr = 4'd3;
    wr(3'd1, 4'd3, 64'hABC, 4'hF, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r3", rf.dbg_data, 64'h0);
    chk("arst_sp", rf.sp_val, 64'h0);
    chk("arst_halt", rf.halted, 64'd0);
    chk("arst_stat", rf.stat_out, 64'd1);
    chk("arst_cnt", rf.retire_cnt, 64'd0);
    chk("arst_sat", rs.retire_cnt, 64'd0);
    idle();
    #1 rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_regfile_pipe.md
Name: wb_regfile_pipe

Overview:
- Clocked, parametrised Y86-64 register file plus write-back stage for the pipelined processor.
- Takes the resolved W-stage destinations and values, and commits them on the clock edge.
- Serves the D-stage two read ports, with same-cycle write-through bypass.
- Tracks processor status: latches the first non-AOK status and freezes architectural state. Also counts retired instructions.

Parameters:
- DATA_W, 64, register/data width in bits.
- ADDR_W, 4, register-ID width. RNONE is the all-ones ID, 2^ADDR_W-1, and means "no register".
- NREG, 15, number of implemented registers (IDs 0..NREG-1). Must satisfy NREG <= 2^ADDR_W-1.
- SP_ID, 4, ID of the stack pointer. Exposed only on the sp_val debug output.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_valid  in  1  W stage holds a real instruction (0 = bubble).
- w_stat  in  3  W-stage status. AOK=1, HLT=2, ADR=3, INS=4.
- w_dstE  in  ADDR_W  destination for valE. For cmovXX with !Cnd, upstream has already set it to RNONE.
- w_dstM  in  ADDR_W  destination for valM.
- w_valE  in  DATA_W  ALU result.
- w_valM  in  DATA_W  memory read data.
- d_srcA  in  ADDR_W  D-stage read address A.
- d_srcB  in  ADDR_W  D-stage read address B.
- d_valA  out  DATA_W  read data A (combinational, bypassed).
- d_valB  out  DATA_W  read data B (combinational, bypassed).
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data: array contents, no bypass.
- sp_val  out  DATA_W  current contents of register SP_ID.
- stat_out  out  3  architectural status.
- halted  out  1  processor halted.
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately even mid-operation):
  - all NREG registers = 0
  - stat_out = 1 (AOK)
  - halted = 0
  - retire_cnt = 0
- Write-enable: we = w_valid && (w_stat==AOK) && !halted.
- Commit on rising clk when we=1:
  - w_dstE is a valid ID (< NREG): reg[w_dstE] <= w_valE.
  - w_dstM is a valid ID: reg[w_dstM] <= w_valM.
  - w_dstE == w_dstM (both valid): only valM is written. valM has priority; covers popq %rsp.
  - IDs equal to RNONE, or in NREG..RNONE-1, produce no write.
  - Both writes to different registers occur in the same cycle.
- Reads (d_valA, d_valB), evaluated in this order, identically for A and B:
  - src is RNONE or >= NREG: return 0.
  - else if we && src==w_dstM: return w_valM.
  - else if we && src==w_dstE: return w_valE.
  - else: return reg[src].
  - Bypass is zero-latency, purely combinational from W inputs. No bypass when we=0.
- dbg_data and sp_val:
  - show registered contents only; they update the cycle after the write.
  - dbg_addr that is invalid returns 0.
- Status:
  - On an edge with w_valid && w_stat!=AOK && !halted: stat_out <= w_stat, halted <= 1.
  - No register write and no count on that edge.
  - Unknown codes (0, 5-7) also halt and are captured verbatim.
  - Once halted, the register array, stat_out and retire_cnt are frozen until reset. Reads remain functional.
- retire_cnt:
  - Increments by 1 on each edge with we=1, including instructions with both dsts = RNONE (nop, jXX, rmmovq).
  - Saturates at 2^CNT_W-1; no wrap.
- Bubbles (w_valid=0) change nothing, regardless of the other W inputs.

Test Plan:
- Reset, then read all IDs → d_valA=d_valB=0, stat_out=1, halted=0, retire_cnt=0. Assert rst_n mid-write → state cleared immediately, before the next edge.
- w_dstE=3, w_valE=0x1234, d_srcA=3, same cycle → d_valA=0x1234 before the edge. Next cycle w_valid=0 → d_valA=0x1234 from the array; dbg_addr=3 gives 0x1234.
- popq %rsp: w_dstE=4, w_valE=0x100, w_dstM=4, w_valM=0xBEEF → sp_val=0xBEEF after the edge, and the bypass also gives 0xBEEF. Separately, dstE=4 / dstM=7 → both written in one edge.
- w_stat=2 (HLT) with w_dstE=1, w_valE=0x55 → reg1 unchanged, halted=1, stat_out=2. Subsequent AOK writes to reg1 → ignored, retire_cnt unchanged, stat_out stays 2.
- cmov not-taken (w_dstE=RNONE), plus d_srcB=RNONE and ID 15 with NREG=15 → no write, d_valB=0, retire_cnt increments by 1.
- CNT_W=3: 9 AOK retirements → retire_cnt=7 (saturated). Bubbles interleaved do not count.
